// File: rtl/factorial_seq_ctrl.sv
// ============================================================================
// factorial_seq_ctrl
// ----------------------------------------------------------------------------
// Sequential factorial engine. A start/busy/done controller drives a single
// shared OUT_W x N multiplier and performs one multiply per clock. This block
// computes n*(n-1)*...*2 iteratively, which is much smaller in area than a
// fully combinational factorial array.
//
// Parameters
//   N      width of the number input (largest operand is 2^N-1)
//   OUT_W  width of the factorial result / accumulator
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high (wins over start)
//   start      in   1      request; only sampled while IDLE
//   number     in   N      operand, captured on the accepting edge only
//   busy       out  1      high while the multiply loop runs (CALC)
//   done       out  1      one-cycle completion pulse (DONE)
//   factorial  out  OUT_W  result; holds until the next completion
//   overflow   out  1      true result needed more than OUT_W bits
//
// Build option
//   FACT_SATURATE_EN  when defined, an overflowed result is reported as
//                     all-ones; otherwise it is the product mod 2^OUT_W.
//                     The overflow flag is identical in both builds.
//
// Timing
//   done rises max(n,1) edges after the accepting edge. factorial and
//   overflow update on that same edge. Back-to-back interval is
//   max(n,1)+2 cycles (DONE always returns through one IDLE cycle).
// ============================================================================
module factorial_seq_ctrl #(
    parameter int unsigned N     = 4,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     number,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] factorial,
    output logic             overflow
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [OUT_W-1:0] r_acc;        // running product, wraps mod 2^OUT_W
    logic [N-1:0]     r_cnt;        // next multiplier operand, counts down
    logic             r_ovf;        // sticky overflow for the current operation
    logic [OUT_W-1:0] r_factorial;  // published result
    logic             r_overflow;   // published overflow flag

    // ------------------------------------------------------------------------
    // Control strobes from the next-state logic
    // ------------------------------------------------------------------------
    logic w_accept;   // IDLE and start: load operand
    logic w_step;     // CALC with cnt > 1: perform one multiply
    logic w_finish;   // CALC with cnt <= 1: publish result

    // ------------------------------------------------------------------------
    // Shared multiplier. Both operands are zero-extended to the full product
    // width so the multiply is evaluated at OUT_W+N bits and the upper N bits
    // expose any carry beyond the accumulator.
    // ------------------------------------------------------------------------
    logic [OUT_W+N-1:0] w_prod;
    logic [OUT_W+N-1:0] w_acc_ext;
    logic [OUT_W+N-1:0] w_cnt_ext;
    logic               w_prod_hi_nz;
    logic               w_cnt_le1;
    logic [OUT_W-1:0]   w_result;

    assign w_acc_ext    = {{N{1'b0}}, r_acc};
    assign w_cnt_ext    = {{OUT_W{1'b0}}, r_cnt};
    assign w_prod       = w_acc_ext * w_cnt_ext;
    assign w_prod_hi_nz = |w_prod[OUT_W+N-1:OUT_W];

    // n=0 and n=1 both terminate immediately with acc=1.
    assign w_cnt_le1    = (r_cnt <= N'(1));

    // Value published on completion.
`ifdef FACT_SATURATE_EN
    assign w_result = r_ovf ? '1 : r_acc;
`else
    assign w_result = r_acc;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end

            S_CALC: begin
                busy = 1'b1;
                if (w_cnt_le1) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_step      = 1'b1;
                end
            end

            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operand capture, iteration, and result publication.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_factorial <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc <= OUT_W'(1);
                r_cnt <= number;
                r_ovf <= 1'b0;
            end else if (w_step) begin
                // Low bits keep wrapping; overflow stays sticky once set.
                r_acc <= w_prod[OUT_W-1:0];
                r_cnt <= r_cnt - N'(1);
                r_ovf <= r_ovf | w_prod_hi_nz;
            end

            if (w_finish) begin
                r_factorial <= w_result;
                r_overflow  <= r_ovf;
            end
        end
    end

    assign factorial = r_factorial;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_factorial_seq_ctrl.sv
// ============================================================================
// tb_factorial_seq_ctrl
// ----------------------------------------------------------------------------
// Directed self-checking bench for factorial_seq_ctrl with N=4, OUT_W=32.
// Inputs are driven 1 ns after a rising edge and outputs are sampled at the
// same point, so each sample reflects the state after the preceding edge.
// ============================================================================
module tb_factorial_seq_ctrl;

    localparam int N     = 4;
    localparam int OUT_W = 32;
    localparam int MAX_WAIT = 64;

    logic             clk;
    logic             rst;
    logic             start;
    logic [N-1:0]     number;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] factorial;
    logic             overflow;

    int errors;
    int checks;
    int done_cnt;

`ifdef FACT_SATURATE_EN
    localparam logic [OUT_W-1:0] EXP_F13 = 32'hFFFF_FFFF;
    localparam logic [OUT_W-1:0] EXP_F15 = 32'hFFFF_FFFF;
`else
    localparam logic [OUT_W-1:0] EXP_F13 = 32'd1932053504;  // 13! mod 2^32
    localparam logic [OUT_W-1:0] EXP_F15 = 32'd2004310016;  // 15! mod 2^32
`endif

    factorial_seq_ctrl #(
        .N     (N),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .number    (number),
        .busy      (busy),
        .done      (done),
        .factorial (factorial),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done is seen or the budget runs out. lat is the number of
    // edges since the accept edge; busy_cnt counts busy samples before done.
    task automatic wait_done(input int lat_in, input int busy_in,
                             output int lat, output int busy_cnt);
        lat      = lat_in;
        busy_cnt = busy_in;
        while (done !== 1'b1 && lat < MAX_WAIT) begin
            tick();
            lat++;
            if (done !== 1'b1 && busy === 1'b1) busy_cnt++;
        end
    endtask

    // One complete operation with its own inline checks.
    task automatic run_op(input string name, input logic [N-1:0] n,
                          input logic [OUT_W-1:0] exp_f, input logic exp_o,
                          input int exp_lat);
        int lat;
        int bcnt;
        logic [OUT_W-1:0] held;
        number = n;
        start  = 1'b1;
        tick();                       // accept edge
        start  = 1'b0;
        number = ~n;                  // must not affect the running operation

        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
        end

        wait_done(0, 1, lat, bcnt);

        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (bcnt !== exp_lat) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, bcnt, exp_lat);
        end
        checks++;
        if (factorial !== exp_f) begin
            errors++;
            $display("FAIL %s factorial: got %0d want %0d", name, factorial, exp_f);
        end
        checks++;
        if (overflow !== exp_o) begin
            errors++;
            $display("FAIL %s overflow: got %b want %b", name, overflow, exp_o);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b want 0", name, busy);
        end

        held = exp_f;
        tick();                       // back to IDLE
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: got %b want 0", name, done);
        end
        checks++;
        if (factorial !== held) begin
            errors++;
            $display("FAIL %s factorial_hold: got %0d want %0d", name, factorial, held);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b1;                // rst must win over start
        number = 4'd5;
        tick();
        tick();
        checks++;
        if ({busy, done, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b ovf=%b want 0 0 0",
                     busy, done, overflow);
        end
        checks++;
        if (factorial !== '0) begin
            errors++;
            $display("FAIL reset_factorial: got %0d want 0", factorial);
        end
        start = 1'b0;
        rst   = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_after_release: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_zero_one();
        run_op("n0", 4'd0, 32'd1, 1'b0, 1);
        run_op("n1", 4'd1, 32'd1, 1'b0, 1);
    endtask

    task automatic test_main();
        run_op("n5",  4'd5,  32'd120,       1'b0, 5);
        run_op("n12", 4'd12, 32'd479001600, 1'b0, 12);
        run_op("n13", 4'd13, EXP_F13,       1'b1, 13);
        run_op("n15", 4'd15, EXP_F15,       1'b1, 15);
        // Overflow must not leak into the next operation.
        run_op("n3_after_ovf", 4'd3, 32'd6, 1'b0, 3);
    endtask

    task automatic test_back_to_back();
        int lat;
        int bcnt;
        int base;
        base   = done_cnt;
        number = 4'd6;
        start  = 1'b1;
        tick();                       // accept n=6
        start  = 1'b0;
        tick();
        tick();
        number = 4'd3;                // ignored pulse while busy
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done(3, 3, lat, bcnt);

        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d want 6", lat);
        end
        checks++;
        if (factorial !== 32'd720) begin
            errors++;
            $display("FAIL b2b_first_factorial: got %0d want 720", factorial);
        end

        // Hold start through DONE; it must only be taken in the IDLE cycle.
        number = 4'd3;
        start  = 1'b1;
        tick();                       // DONE -> IDLE, start ignored here
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: got busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (done_cnt - base !== 1) begin
            errors++;
            $display("FAIL b2b_single_done: got %0d pulses want 1", done_cnt - base);
        end
        tick();                       // accept n=3
        start  = 1'b0;
        number = 4'd9;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept: got busy=%b want 1", busy);
        end
        wait_done(0, 1, lat, bcnt);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL b2b_second_latency: got %0d want 3", lat);
        end
        checks++;
        if (factorial !== 32'd6) begin
            errors++;
            $display("FAIL b2b_second_factorial: got %0d want 6", factorial);
        end
        tick();
    endtask

    task automatic test_reset_mid_calc();
        int base;
        number = 4'd9;
        start  = 1'b1;
        tick();                       // accept n=9
        start  = 1'b0;
        tick();
        tick();
        tick();
        base = done_cnt;
        rst  = 1'b1;
        tick();
        checks++;
        if ({busy, done, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_flags: got busy=%b done=%b ovf=%b want 0 0 0",
                     busy, done, overflow);
        end
        checks++;
        if (factorial !== '0) begin
            errors++;
            $display("FAIL midrst_factorial: got %0d want 0", factorial);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (done_cnt !== base) begin
            errors++;
            $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - base);
        end
        run_op("n4_after_rst", 4'd4, 32'd24, 1'b0, 4);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        number   = '0;

        test_reset();
        test_zero_one();
        test_main();
        test_back_to_back();
        test_reset_mid_calc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
